multicycle_controller: RTL and testbench

Control FSM for the multi-cycle variant of the RISC-V core. It sequences the shared datapath: one memory port, one ALU, the PC/IR/data registers and the register file. Each instruction is decoded from the opcode held in the IR. The FSM steps that instruction through fetch, decode, execute, memory and writeback. It waits on a memory-ready handshake, flags illegal opcodes and counts retired instructions. The instruction subset matches the single-cycle main decoder: lw, sw, R-type, I-type ALU, beq and jal.

---
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RISC-V core. It sequences fetch/decode/execute/memory/writeback
// over a shared datapath, waits on MemReady, flags illegal opcodes and counts retired instructions.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrRetired
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    // State register is plain logic so that out-of-range codes remain representable and recover.
    logic [3:0]       state_r;
    logic [3:0]       next_s;
    logic [CNT_W-1:0] retired_r;
    logic             retire_s;
    logic             pcupdate_s;
    logic             branch_s;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            OP_LW:   sel = 2'b00;
            OP_I:    sel = 2'b00;
            OP_SW:   sel = 2'b01;
            OP_BEQ:  sel = 2'b10;
            OP_JAL:  sel = 2'b11;
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_FETCH;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_s;
            if (retire_s) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Next-state and Moore output decode; FETCH handshake outputs follow MemReady.
    always_comb begin
        next_s     = S_FETCH;
        retire_s   = 1'b0;
        pcupdate_s = 1'b0;
        branch_s   = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        RegWrite   = 1'b0;
        Illegal    = 1'b0;
        case (state_r)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                IRWrite    = MemReady;
                pcupdate_s = MemReady;
                next_s     = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Opcode)
                    OP_LW:   next_s = S_MEMADR;
                    OP_SW:   next_s = S_MEMADR;
                    OP_R:    next_s = S_EXECUTER;
                    OP_I:    next_s = S_EXECUTEI;
                    OP_BEQ:  next_s = S_BEQ;
                    OP_JAL:  next_s = S_JAL;
                    default: begin
                        next_s  = S_FETCH;
                        Illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                next_s  = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                next_s = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire_s  = 1'b1;
                next_s    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire_s = MemReady;
                next_s   = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                next_s  = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                next_s  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire_s = 1'b1;
                next_s   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                branch_s = 1'b1;
                retire_s = 1'b1;
                next_s   = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pcupdate_s = 1'b1;
                next_s     = S_ALUWB;
            end
            default: begin
                next_s = S_FETCH;
            end
        endcase
    end

    assign PCWrite      = pcupdate_s | (branch_s & Zero);
    assign ImmSrc       = imm_sel(Opcode);
    assign State        = state_r;
    assign InstrRetired = retired_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction state paths and control outputs
// are predicted from the instruction-level rules and compared cycle by cycle.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [6:0]  Opcode;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0]  State;
    logic [31:0] InstrRetired;

    int checks   = 0;
    int failures = 0;
    int exp_retired = 0;
    int mw_cnt, pcw_cnt, ill_cnt, rw_cnt, cyc_cnt;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Illegal(Illegal), .State(State),
        .InstrRetired(InstrRetired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [6:0] op);
        return (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == BEQ) || (op == JAL);
    endfunction

    // Control word predicted from the per-state table: {PCWrite,AdrSrc,MemWrite,IRWrite,
    // ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,RegWrite,Illegal}.
    function automatic logic [15:0] exp_out(input int st, input logic rdy, input logic z,
                                            input logic [6:0] op);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, ao, im;
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00;
        im = (op == SW) ? 2'b01 : (op == BEQ) ? 2'b10 : (op == JAL) ? 2'b11 : 2'b00;
        case (st)
            0:  begin sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            1:  begin sa = 2'b01; sb = 2'b01; ill = !is_legal(op); end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1'b1;
            4:  begin rs = 2'b01; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  begin sa = 2'b10; ao = 2'b10; end
            7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            8:  rw = 1'b1;
            9:  begin sa = 2'b10; ao = 2'b01; pcw = z; end
            10: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, rs, sa, sb, ao, im, rw, ill};
    endfunction

    // Runs one instruction from FETCH, checking state and controls every cycle.
    task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input logic zbeq);
        int st_q[$];
        logic rdy_q[$];
        logic [15:0] act, expv;
        logic z;
        mw_cnt = 0; pcw_cnt = 0; ill_cnt = 0; rw_cnt = 0; cyc_cnt = 0;
        repeat (fs) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
        st_q.push_back(0); rdy_q.push_back(1'b1);
        st_q.push_back(1); rdy_q.push_back(1'($urandom_range(0, 1)));
        if (op == LW || op == SW) begin
            st_q.push_back(2); rdy_q.push_back(1'($urandom_range(0, 1)));
            repeat (ms) begin st_q.push_back(op == LW ? 3 : 5); rdy_q.push_back(1'b0); end
            st_q.push_back(op == LW ? 3 : 5); rdy_q.push_back(1'b1);
            if (op == LW) begin st_q.push_back(4); rdy_q.push_back(1'($urandom_range(0, 1))); end
        end else if (op == RT || op == IT) begin
            st_q.push_back(op == RT ? 6 : 7); rdy_q.push_back(1'($urandom_range(0, 1)));
            st_q.push_back(8); rdy_q.push_back(1'($urandom_range(0, 1)));
        end else if (op == BEQ) begin
            st_q.push_back(9); rdy_q.push_back(1'($urandom_range(0, 1)));
        end else if (op == JAL) begin
            st_q.push_back(10); rdy_q.push_back(1'($urandom_range(0, 1)));
            st_q.push_back(8); rdy_q.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < st_q.size(); i++) begin
            z = (st_q[i] == 9) ? zbeq : 1'($urandom_range(0, 1));
            Opcode = op; MemReady = rdy_q[i]; Zero = z;
            #1;
            checks++;
            if (State !== 4'(st_q[i])) begin
                failures++;
                $display("FAIL state op=%b cyc=%0d got=%0d want=%0d", op, i, State, st_q[i]);
            end
            act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
                   ImmSrc, RegWrite, Illegal};
            expv = exp_out(st_q[i], rdy_q[i], z, op);
            checks++;
            if (act !== expv) begin
                failures++;
                $display("FAIL controls op=%b st=%0d got=%h want=%h", op, st_q[i], act, expv);
            end
            mw_cnt += int'(MemWrite); pcw_cnt += int'(PCWrite && State != 0);
            ill_cnt += int'(Illegal); rw_cnt += int'(RegWrite); cyc_cnt++;
            @(posedge clk); #1;
        end
        if (is_legal(op)) exp_retired++;
        checks++;
        if (InstrRetired !== 32'(exp_retired)) begin
            failures++;
            $display("FAIL retired op=%b got=%0d want=%0d", op, InstrRetired, exp_retired);
        end
        MemReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; MemReady = 1'b1; Opcode = LW; Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0; MemReady = 1'b0; #1;
        checks++;
        if (State !== 4'd0 || InstrRetired !== 32'd0 || Illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got st=%0d ret=%0d ill=%b want 0 0 0", State, InstrRetired, Illegal);
        end
        checks++;
        if (IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready0 got ir=%b pc=%b want 0 0", IRWrite, PCWrite);
        end
        MemReady = 1'b1; #1;
        checks++;
        if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready1 got ir=%b pc=%b want 1 1", IRWrite, PCWrite);
        end
        MemReady = 1'b0;
        exp_retired = 0;
    endtask

    task automatic test_lw();
        run_instr(LW, 0, 0, 1'b0);
        checks++;
        if (cyc_cnt != 5 || rw_cnt != 1) begin
            failures++;
            $display("FAIL lw_latency got cyc=%0d rw=%0d want 5 1", cyc_cnt, rw_cnt);
        end
    endtask

    task automatic test_sw_stall();
        run_instr(SW, 0, 3, 1'b0);
        checks++;
        if (mw_cnt != 4 || cyc_cnt != 7) begin
            failures++;
            $display("FAIL sw_stall got mw=%0d cyc=%0d want 4 7", mw_cnt, cyc_cnt);
        end
    endtask

    task automatic test_beq();
        run_instr(BEQ, 0, 0, 1'b1);
        checks++;
        if (pcw_cnt != 1 || cyc_cnt != 3) begin
            failures++;
            $display("FAIL beq_taken got pcw=%0d cyc=%0d want 1 3", pcw_cnt, cyc_cnt);
        end
        run_instr(BEQ, 0, 0, 1'b0);
        checks++;
        if (pcw_cnt != 0 || cyc_cnt != 3) begin
            failures++;
            $display("FAIL beq_nottaken got pcw=%0d cyc=%0d want 0 3", pcw_cnt, cyc_cnt);
        end
    endtask

    task automatic test_jal();
        run_instr(JAL, 1, 0, 1'b0);
        checks++;
        if (pcw_cnt != 1 || rw_cnt != 1 || cyc_cnt != 5) begin
            failures++;
            $display("FAIL jal got pcw=%0d rw=%0d cyc=%0d want 1 1 5", pcw_cnt, rw_cnt, cyc_cnt);
        end
    endtask

    task automatic test_illegal();
        run_instr(7'b1111111, 0, 0, 1'b0);
        checks++;
        if (ill_cnt != 1 || cyc_cnt != 2) begin
            failures++;
            $display("FAIL illegal got pulses=%0d cyc=%0d want 1 2", ill_cnt, cyc_cnt);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [0:5];
        logic [6:0] op;
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BEQ; ops[5] = JAL;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            else op = ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_midstall();
        int seq_st [0:4];
        logic seq_rdy [0:4];
        seq_st[0] = 0; seq_st[1] = 1; seq_st[2] = 2; seq_st[3] = 3; seq_st[4] = 3;
        seq_rdy[0] = 1'b1; seq_rdy[1] = 1'b1; seq_rdy[2] = 1'b1; seq_rdy[3] = 1'b0; seq_rdy[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Opcode = LW; MemReady = seq_rdy[i]; #1;
            checks++;
            if (State !== 4'(seq_st[i])) begin
                failures++;
                $display("FAIL midstall_path cyc=%0d got=%0d want=%0d", i, State, seq_st[i]);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1; MemReady = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_retired = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (State !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0 || InstrRetired !== 32'd0) begin
                failures++;
                $display("FAIL midstall_reset got st=%0d ir=%b pc=%b ret=%0d want 0 0 0 0",
                         State, IRWrite, PCWrite, InstrRetired);
            end
            @(posedge clk); #1;
        end
        MemReady = 1'b1; #1;
        checks++;
        if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
            failures++;
            $display("FAIL midstall_resume got ir=%b pc=%b want 1 1", IRWrite, PCWrite);
        end
        MemReady = 1'b0;
        run_instr(LW, 1, 2, 1'b0);
    endtask

    initial begin
        reset = 1'b1; Opcode = 7'd0; Zero = 1'b0; MemReady = 1'b0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_jal();
        test_illegal();
        test_random();
        test_reset_midstall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
